// File: rtl/mux8t1_32_sync.sv
// 8-to-1 datapath multiplexer with a zero-latency output, a registered copy
// of the selected data/select, a one-hot select decode and a select-change strobe.
module mux8t1_32_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic [WIDTH-1:0] I4,
  input  logic [WIDTH-1:0] I5,
  input  logic [WIDTH-1:0] I6,
  input  logic [WIDTH-1:0] I7,
  input  logic [2:0]       s,
  input  logic             en,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q,
  output logic [2:0]       s_q,
  output logic [7:0]       sel_oh,
  output logic             s_chg
);

  logic [WIDTH-1:0] o_d;
  logic [2:0]       s_d;
  logic             s_chg_d;
  logic             s_chg_q;

  always_comb begin
    // NOTE: assign a default before the case so no path leaves o unassigned,
    // which would otherwise infer a latch.
    o = I0;
    case (s)
      3'd1:    o = I1;
      3'd2:    o = I2;
      3'd3:    o = I3;
      3'd4:    o = I4;
      3'd5:    o = I5;
      3'd6:    o = I6;
      3'd7:    o = I7;
      default: o = I0;
    endcase
  end

  assign sel_oh = 8'b0000_0001 << s;

  // The strobe compares against the select captured on the previous load,
  // not the previous cycle, so idle cycles between loads do not hide a change.
  always_comb begin
    o_d     = o_q;
    s_d     = s_q;
    s_chg_d = 1'b0;
    if (en) begin
      o_d     = o;
      s_d     = s;
      s_chg_d = (s != s_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q     <= '0;
      s_q     <= '0;
      s_chg_q <= 1'b0;
    end else begin
      o_q     <= o_d;
      s_q     <= s_d;
      s_chg_q <= s_chg_d;
    end
  end

  assign s_chg = s_chg_q;

endmodule

// File: tb/tb_mux8t1_32_sync.sv
// Self-checking bench for mux8t1_32_sync: directed scenarios followed by
// randomized stimulus compared against an array-based reference model.
module tb_mux8t1_32_sync;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din [8];
  logic [2:0]       s;
  logic             en;
  logic [WIDTH-1:0] o;
  logic [WIDTH-1:0] o_q;
  logic [2:0]       s_q;
  logic [7:0]       sel_oh;
  logic             s_chg;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the registered path.
  logic [WIDTH-1:0] m_oq  = '0;
  logic [2:0]       m_sq  = '0;
  logic             m_chg = 1'b0;

  mux8t1_32_sync #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .I0(din[0]), .I1(din[1]), .I2(din[2]), .I3(din[3]),
    .I4(din[4]), .I5(din[5]), .I6(din[6]), .I7(din[7]),
    .s(s), .en(en),
    .o(o), .o_q(o_q), .s_q(s_q), .sel_oh(sel_oh), .s_chg(s_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      m_oq  <= '0;
      m_sq  <= '0;
      m_chg <= 1'b0;
    end else if (en) begin
      m_oq  <= din[s];
      m_sq  <= s;
      m_chg <= (s != m_sq);
    end else begin
      m_chg <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] onehot(input logic [2:0] sel);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = (int'(sel) == k);
    return r;
  endfunction

  task automatic check_comb(input string tag);
    check({tag, "_o"}, o, din[s]);
    check({tag, "_oh"}, {24'd0, sel_oh}, {24'd0, onehot(s)});
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_oq"}, o_q, m_oq);
    check({tag, "_sq"}, {29'd0, s_q}, {29'd0, m_sq});
    check({tag, "_chg"}, {31'd0, s_chg}, {31'd0, m_chg});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with all inputs zero.
    rst = 1'b1; en = 1'b0; s = 3'd0;
    for (int k = 0; k < 8; k++) din[k] = '0;
    tick(); tick();
    check("rst_o", o, 32'd0);
    check("rst_oq", o_q, 32'd0);
    check("rst_sq", {29'd0, s_q}, 32'd0);
    check("rst_chg", {31'd0, s_chg}, 32'd0);
    rst = 1'b0;

    // Sweep the select with en low: o follows immediately, o_q holds 0.
    for (int k = 0; k < 8; k++) din[k] = WIDTH'(k + 1);
    for (int k = 0; k < 8; k++) begin
      s = 3'(k);
      #1;
      check("sweep_o", o, WIDTH'(k + 1));
      check("sweep_oh", {24'd0, sel_oh}, 32'd1 << k);
      #49;
      check("sweep_oq_hold", o_q, 32'd0);
    end

    // Wrap from 7 back to 0.
    s = s + 3'd1;
    #1;
    check("wrap_s", {29'd0, s}, 32'd0);
    check("wrap_o", o, 32'd1);

    // Select change 3 -> 6 between loads raises the strobe for one load.
    s = 3'd3; en = 1'b1;
    tick();
    check_regs("load3");
    s = 3'd6;
    tick();
    check("chg_oq", o_q, 32'd7);
    check("chg_sq", {29'd0, s_q}, 32'd6);
    check("chg_pulse", {31'd0, s_chg}, 32'd1);
    tick();
    check("chg_clear", {31'd0, s_chg}, 32'd0);

    // Unselected input has no effect on o.
    en = 1'b0; s = 3'd2;
    #1;
    check("sel2_o", o, 32'd3);
    din[5] = 32'hDEAD_BEEF;
    #1;
    check("unsel_o", o, 32'd3);
    s = 3'd5;
    #1;
    check("sel5_o", o, 32'hDEAD_BEEF);
    en = 1'b1;
    tick();
    check("sel5_oq", o_q, 32'hDEAD_BEEF);
    check_regs("sel5");

    // Reset wins over enable; combinational o untouched.
    din[5] = 32'd6; s = 3'd7; rst = 1'b1;
    #1;
    check("rsten_o_pre", o, 32'd8);
    tick();
    check("rsten_oq", o_q, 32'd0);
    check("rsten_sq", {29'd0, s_q}, 32'd0);
    check("rsten_chg", {31'd0, s_chg}, 32'd0);
    check("rsten_o_post", o, 32'd8);
    rst = 1'b0;

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 8; k++) din[k] = $urandom;
      s   = 3'($urandom_range(0, 7));
      en  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 19) == 0);
      #1;
      check_comb("rnd");
      tick();
      check_regs("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
